// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller, its button/prescaler sources
// and the display formatter.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic       cnt_max;
    logic       cnt_en;
    logic       cnt_clr;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic       running;
    logic       lap_active;
    logic       rollover;

    modport master (
        output btn_ss, btn_lap, btn_clr, cnt_max,
        input  cnt_en, cnt_clr, disp_sec, disp_min, running, lap_active, rollover
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr, cnt_max,
        output cnt_en, cnt_clr, disp_sec, disp_min, running, lap_active, rollover
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button presses drive a 4-state FSM that gates the 1 s
// prescaler and accumulates its terminal-count ticks into min:sec with lap freeze.
module stopwatch_ctrl #(
    parameter int unsigned SEC_WRAP = 60,
    parameter int unsigned MIN_WRAP = 60
) (
    input logic             clk,
    input logic             rst,
    stopwatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

    localparam logic [5:0] SecMax = 6'(SEC_WRAP - 1);
    localparam logic [5:0] MinMax = 6'(MIN_WRAP - 1);

    state_e     state_q;
    logic       ss_prev_q, lap_prev_q, clr_prev_q;
    logic [5:0] sec_q, min_q, lap_sec_q, lap_min_q;
    logic       cnt_clr_q, rollover_q;

    logic press_ss, press_lap, press_clr, tick;

    always_comb begin
        press_ss  = bus.btn_ss & ~ss_prev_q;
        press_lap = bus.btn_lap & ~lap_prev_q;
        press_clr = bus.btn_clr & ~clr_prev_q;
        tick      = bus.cnt_en & bus.cnt_max;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ss_prev_q  <= 1'b0;
            lap_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
            sec_q      <= '0;
            min_q      <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            cnt_clr_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            ss_prev_q  <= bus.btn_ss;
            lap_prev_q <= bus.btn_lap;
            clr_prev_q <= bus.btn_clr;
            cnt_clr_q  <= 1'b0;
            rollover_q <= 1'b0;

            if (tick) begin
                if (sec_q != SecMax) begin
                    sec_q <= sec_q + 6'd1;
                end else begin
                    sec_q <= '0;
                    if (min_q != MinMax) begin
                        min_q <= min_q + 6'd1;
                    end else begin
                        min_q      <= '0;
                        rollover_q <= 1'b1;
                    end
                end
            end

            // Clear is only valid in PAUSE, so ss>lap is the only priority left elsewhere.
            unique case (state_q)
                StIdle: begin
                    if (press_ss) state_q <= StRun;
                end
                StRun: begin
                    if (press_ss) begin
                        state_q <= StPause;
                    end else if (press_lap) begin
                        state_q   <= StLap;
                        lap_sec_q <= sec_q;
                        lap_min_q <= min_q;
                    end
                end
                StLap: begin
                    if (press_ss)       state_q <= StPause;
                    else if (press_lap) state_q <= StRun;
                end
                StPause: begin
                    if (press_clr) begin
                        state_q   <= StIdle;
                        sec_q     <= '0;
                        min_q     <= '0;
                        cnt_clr_q <= 1'b1;
                    end else if (press_ss) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.running    = (state_q == StRun) || (state_q == StLap);
        bus.lap_active = (state_q == StLap);
        bus.cnt_en     = bus.running;
        bus.cnt_clr    = cnt_clr_q;
        bus.rollover   = rollover_q;
        bus.disp_sec   = bus.lap_active ? lap_sec_q : sec_q;
        bus.disp_min   = bus.lap_active ? lap_min_q : min_q;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised bench for stopwatch_ctrl against an elapsed-seconds reference model.
module tb_stopwatch_ctrl;
    localparam int SecWrap = 60;
    localparam int MinWrap = 60;
    localparam int Period  = SecWrap * MinWrap;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .SEC_WRAP(SecWrap),
        .MIN_WRAP(MinWrap)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sw_if.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0 stopped-at-zero, 1 counting, 2 paused, 3 counting with frozen lap view.
    int m_mode, m_elapsed, m_snap;
    bit m_ss_prev, m_lap_prev, m_clr_prev, m_clr_pulse, m_roll_pulse;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_snap = 0;
        m_ss_prev = 0; m_lap_prev = 0; m_clr_prev = 0;
        m_clr_pulse = 0; m_roll_pulse = 0;
    endtask

    task automatic check_outputs();
        bit counting;
        int shown;
        counting = (m_mode == 1) || (m_mode == 3);
        shown    = (m_mode == 3) ? m_snap : m_elapsed;
        check_eq("cnt_en", int'(sw_if.cnt_en), int'(counting));
        check_eq("running", int'(sw_if.running), int'(counting));
        check_eq("lap_active", int'(sw_if.lap_active), int'(m_mode == 3));
        check_eq("disp_sec", int'(sw_if.disp_sec), shown % SecWrap);
        check_eq("disp_min", int'(sw_if.disp_min), shown / SecWrap);
        check_eq("cnt_clr", int'(sw_if.cnt_clr), int'(m_clr_pulse));
        check_eq("rollover", int'(sw_if.rollover), int'(m_roll_pulse));
    endtask

    // One clock: check present outputs, apply inputs, advance the model to the next cycle.
    task automatic cycle(input bit r, input bit ss, input bit lap, input bit clr, input bit cmax);
        bit p_ss, p_lap, p_clr, counting;
        @(negedge clk);
        check_outputs();
        rst = r;
        sw_if.btn_ss = ss; sw_if.btn_lap = lap; sw_if.btn_clr = clr; sw_if.cnt_max = cmax;
        if (r) begin
            model_reset();
            return;
        end
        p_ss  = ss && !m_ss_prev;
        p_lap = lap && !m_lap_prev;
        p_clr = clr && !m_clr_prev;
        m_ss_prev = ss; m_lap_prev = lap; m_clr_prev = clr;
        counting = (m_mode == 1) || (m_mode == 3);
        m_clr_pulse  = 0;
        m_roll_pulse = 0;
        case (m_mode)
            0: if (p_ss) m_mode = 1;
            1: if (p_ss) m_mode = 2;
               else if (p_lap) begin m_mode = 3; m_snap = m_elapsed; end
            3: if (p_ss) m_mode = 2; else if (p_lap) m_mode = 1;
            default: if (p_clr) begin
                         m_mode = 0; m_elapsed = 0; m_clr_pulse = 1;
                     end else if (p_ss) m_mode = 1;
        endcase
        if (counting && cmax) begin
            if (m_elapsed == Period - 1) m_roll_pulse = 1;
            m_elapsed = (m_elapsed + 1) % Period;
        end
    endtask

    initial begin
        bit ss, lap, clr;
        sw_if.btn_ss = 0; sw_if.btn_lap = 0; sw_if.btn_clr = 0; sw_if.cnt_max = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Start, then five ticks.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        check_eq("plan_sec5", int'(sw_if.disp_sec), 5);

        // Pause, all three buttons rise together: clear wins.
        cycle(0, 1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 0);

        // Long ss hold gives a single RUN entry.
        repeat (10) cycle(0, 1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Random traffic.
        ss = 0; lap = 0; clr = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(7) == 0) ss  = !ss;
            if ($urandom_range(7) == 0) lap = !lap;
            if ($urandom_range(7) == 0) clr = !clr;
            cycle(($urandom_range(299) == 0), ss, lap, clr, ($urandom_range(1) == 1));
        end

        // Full-period run to exercise max:max -> 0:00 rollover.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < Period + 3; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        check_eq("wrap_sec", int'(sw_if.disp_sec), 3);
        cycle(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the 1-second prescaler counter (27-bit, terminal count 99_999_999, outputs `cnt_max`).
- Turns debounced start/stop, lap and clear buttons into the counter's `en`/`clr` controls via a 4-state FSM.
- Accumulates the counter's terminal-count ticks into seconds/minutes, with a lap-freeze display path.
- Sits between the button debouncers and the 7-segment display formatter.

Parameters:
- SEC_WRAP, 60: seconds modulus; `sec` counts 0..SEC_WRAP-1.
- MIN_WRAP, 60: minutes modulus; `min` counts 0..MIN_WRAP-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_ss  input  1  start/stop button level, already debounced and synchronous to `clk`.
- btn_lap  input  1  lap button level, debounced, synchronous.
- btn_clr  input  1  clear button level, debounced, synchronous.
- cnt_max  input  1  terminal-count flag from the prescaler counter.
- cnt_en  output  1  enable to the prescaler counter.
- cnt_clr  output  1  clear to the prescaler counter; one-cycle pulse.
- disp_sec  output  6  seconds value for display.
- disp_min  output  6  minutes value for display.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP.
- rollover  output  1  one-cycle pulse on wrap from max:max to 0:0.

Behaviour:
- Reset: clk and rst as decided: one clock; reset is synchronous and active-high. While `rst`=1 on a rising edge:
  - state=IDLE.
  - internal sec/min=0, lap latch=0.
  - button history registers=0.
  - `cnt_clr`=0, `rollover`=0.
  - All outputs therefore read 0 on the first cycle after reset.
- Edge detect: each button has a registered previous value. A press is `btn & ~btn_prev`: exactly one press per 0->1 transition, no matter how long the button is held.
- States: IDLE, RUN, PAUSE, LAP.
- Press handling:
  - Only presses valid in the current state are considered.
  - If several valid presses occur in the same cycle, priority is clr > ss > lap.
  - Invalid presses are dropped, not queued.
- Transitions (registered, effective next cycle):
  - IDLE: ss -> RUN. lap, clr ignored.
  - RUN: ss -> PAUSE; lap -> LAP, capturing the current sec/min into the lap latch. clr ignored.
  - LAP: lap -> RUN; ss -> PAUSE. clr ignored.
  - PAUSE: ss -> RUN; clr -> IDLE, with sec/min zeroed and `cnt_clr` pulsed high for exactly one cycle (the cycle after the press). lap ignored.
- Counter outputs:
  - `cnt_en` is combinational from state: 1 in RUN and LAP, else 0.
  - `cnt_clr` is registered.
- Tick: `tick = cnt_en & cnt_max`. `cnt_max` held high in PAUSE/IDLE must produce no tick.
- Time arithmetic, applied on `tick`:
  - sec<SEC_WRAP-1: sec+1.
  - Otherwise sec=0 and min increments.
  - If min=MIN_WRAP-1 as well: min=0 and `rollover`=1 for one cycle.
  - No saturation.
- Tick on the cycle of a state change:
  - A tick while in RUN/LAP on the same edge as an ss press (->PAUSE) is still counted, because `cnt_en` was high that cycle.
  - A tick coinciding with LAP entry updates sec/min, but the latch captures the pre-tick values.
- Display:
  - In LAP: `disp_sec`/`disp_min` show the lap latch.
  - In all other states: live sec/min.
  - Leaving LAP (to RUN or PAUSE) shows live values the next cycle.
  - Live time keeps accumulating throughout LAP.
- Output decode: `running` and `lap_active` are combinational state decodes.
- Reset mid-run: dominates all presses and ticks; the next state is IDLE with zeros.

Test Plan:
- Reset, then ss press, then hold `cnt_max`=1 for 5 cycles -> `cnt_en`=1 from the cycle after the press; `disp_sec`=5, `disp_min`=0.
- From RUN at sec=59, min=0, one tick -> sec=0, min=1, `rollover`=0. From sec=59, min=59, one tick -> 0:00 with `rollover` high for exactly 1 cycle.
- RUN at 0:10, lap press, then 7 ticks -> display stays 0:10 with `lap_active`=1. Second lap press -> display shows 0:17 the next cycle.
- Clear handling:
  - RUN at 0:03, clr press -> ignored; time continues.
  - ss press -> PAUSE; `cnt_max` held high 4 cycles -> time stays 0:03.
  - clr press -> IDLE, display 0:00, `cnt_clr` high exactly 1 cycle.
- PAUSE with ss, lap and clr all rising on the same cycle -> clr wins: IDLE, zeros, `cnt_clr` pulse.
- Hold `btn_ss` high for 10 cycles -> single RUN entry. Assert `rst` mid-RUN at 0:42 -> next cycle IDLE, 0:00, `cnt_en`=0.
